hdmi_link_sequencer: RTL and testbench

HDMI_LINK_SEQUENCER -- requirements
Module: hdmi_link_sequencer

---
 rtl/hdmi_link_sequencer_if.sv | 23 ++
 rtl/hdmi_link_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_hdmi_link_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_link_sequencer_if.sv
// Port bundle between the HDMI link sequencer and its environment.
// Inputs are lock/hot-plug/frame status; outputs are reset, enable and status lines.
interface hdmi_link_sequencer_if;
   logic       i_locked;
   logic       i_hpd;
   logic       i_frame;
   logic       o_serdes_rst;
   logic       o_timing_rst;
   logic       o_video_en;
   logic       o_link_up;
   logic [2:0] o_state;
   logic [7:0] o_relink_cnt;

   modport master (
      output i_locked, i_hpd, i_frame,
      input  o_serdes_rst, o_timing_rst, o_video_en, o_link_up, o_state, o_relink_cnt
   );

   modport slave (
      input  i_locked, i_hpd, i_frame,
      output o_serdes_rst, o_timing_rst, o_video_en, o_link_up, o_state, o_relink_cnt
   );
endinterface

// File: rtl/hdmi_link_sequencer.sv
// HDMI bring-up sequencer: waits for clock lock and qualified hot-plug, pulses serializer and
// timing resets, then enables video on frame start. Define HDMI_HPD_BYPASS_EN to tie HPD high.
module hdmi_link_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
   parameter int unsigned SERDES_RST_CYCLES = 64,
   parameter int unsigned TIMING_RST_CYCLES = 16
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   hdmi_link_sequencer_if.slave  bus
);

   localparam int unsigned CNT_MAX = (SERDES_RST_CYCLES > TIMING_RST_CYCLES) ?
                                     SERDES_RST_CYCLES : TIMING_RST_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SERDES_LOAD = CNT_W'(SERDES_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMING_LOAD = CNT_W'(TIMING_RST_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_WAIT_HPD   = 3'd2,
      ST_SERDES_RST = 3'd3,
      ST_TIMING_RST = 3'd4,
      ST_WAIT_FRAME = 3'd5,
      ST_RUN        = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       relink_q, relink_d;
   logic             serdes_rst_q, serdes_rst_d;
   logic             timing_rst_q, timing_rst_d;
   logic             video_en_q, video_en_d;
   logic             link_up_q, link_up_d;
   logic             lock_meta_q, lock_meta_d;
   logic             lock_sync_q, lock_sync_d;
   logic             hpd_qual;
   logic             lock_fault;
   logic             hpd_fault;

   always_comb begin
      lock_meta_d = bus.i_locked;
      lock_sync_d = lock_meta_q;
   end

`ifdef HDMI_HPD_BYPASS_EN
   assign hpd_qual = 1'b1;
`else
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            hpd_meta_q, hpd_meta_d;
   logic            hpd_sync_q, hpd_sync_d;
   logic            hpd_deb_q, hpd_deb_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;

   // Debounce: any sample agreeing with the current state restarts the run count.
   always_comb begin
      hpd_meta_d = bus.i_hpd;
      hpd_sync_d = hpd_meta_q;
      hpd_deb_d  = hpd_deb_q;
      db_cnt_d   = '0;
      if (hpd_sync_q != hpd_deb_q) begin
         if (db_cnt_q == DB_LAST) begin
            hpd_deb_d = ~hpd_deb_q;
            db_cnt_d  = '0;
         end else begin
            db_cnt_d  = db_cnt_q + DB_W'(1);
         end
      end else begin
         db_cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hpd_meta_q <= 1'b0;
         hpd_sync_q <= 1'b0;
         hpd_deb_q  <= 1'b0;
         db_cnt_q   <= '0;
      end else begin
         hpd_meta_q <= hpd_meta_d;
         hpd_sync_q <= hpd_sync_d;
         hpd_deb_q  <= hpd_deb_d;
         db_cnt_q   <= db_cnt_d;
      end
   end

   assign hpd_qual = hpd_deb_q;
`endif

   assign lock_fault = (state_q >= ST_WAIT_HPD) && (state_q <= ST_RUN) && !lock_sync_q;
   assign hpd_fault  = (state_q >= ST_SERDES_RST) && (state_q <= ST_RUN) && !hpd_qual;

   // Lock loss outranks HPD loss, which outranks normal sequencing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (lock_fault) begin
         state_d = ST_WAIT_LOCK;
      end else if (hpd_fault) begin
         state_d = ST_WAIT_HPD;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (lock_sync_q) begin
                  state_d = ST_WAIT_HPD;
               end else begin
                  state_d = ST_WAIT_LOCK;
               end
            end
            ST_WAIT_HPD: begin
               if (hpd_qual) begin
                  state_d = ST_SERDES_RST;
                  cnt_d   = SERDES_LOAD;
               end else begin
                  state_d = ST_WAIT_HPD;
               end
            end
            ST_SERDES_RST: begin
               if (cnt_q == '0) begin
                  state_d = ST_TIMING_RST;
                  cnt_d   = TIMING_LOAD;
               end else begin
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
            ST_TIMING_RST: begin
               if (cnt_q == '0) begin
                  state_d = ST_WAIT_FRAME;
               end else begin
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
            ST_WAIT_FRAME: begin
               if (bus.i_frame) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_WAIT_FRAME;
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      if ((state_q == ST_RUN) && (lock_fault || hpd_fault) && (relink_q != 8'hFF)) begin
         relink_d = relink_q + 8'd1;
      end else begin
         relink_d = relink_q;
      end

      // Outputs are decoded from the next state so the registered copies track state_q.
      serdes_rst_d = (state_d <= ST_SERDES_RST);
      timing_rst_d = (state_d <= ST_TIMING_RST);
      video_en_d   = (state_d == ST_RUN);
      link_up_d    = (state_d == ST_RUN);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lock_meta_q  <= 1'b0;
         lock_sync_q  <= 1'b0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         relink_q     <= 8'd0;
         serdes_rst_q <= 1'b1;
         timing_rst_q <= 1'b1;
         video_en_q   <= 1'b0;
         link_up_q    <= 1'b0;
      end else begin
         lock_meta_q  <= lock_meta_d;
         lock_sync_q  <= lock_sync_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         relink_q     <= relink_d;
         serdes_rst_q <= serdes_rst_d;
         timing_rst_q <= timing_rst_d;
         video_en_q   <= video_en_d;
         link_up_q    <= link_up_d;
      end
   end

   assign bus.o_state      = state_q;
   assign bus.o_serdes_rst = serdes_rst_q;
   assign bus.o_timing_rst = timing_rst_q;
   assign bus.o_video_en   = video_en_q;
   assign bus.o_link_up    = link_up_q;
   assign bus.o_relink_cnt = relink_q;

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// Directed bench for hdmi_link_sequencer (DEBOUNCE=16, SERDES=8, TIMING=4): a vector table for
// the bring-up/glitch/HPD-loss/simultaneous-fault walk, then relink saturation and async reset.
module tb_hdmi_link_sequencer;

   typedef struct {
      int         cyc;
      logic       lk;
      logic       hp;
      logic       fr;
      logic [2:0] st;
      logic [7:0] rc;
   } vec_t;

   logic  i_clk = 1'b0;
   logic  i_rst_n;
   int    checks = 0;
   int    errors = 0;
   vec_t  vec [0:31];
   int    nrows;
   int    rc_base;
   int    exp_rc;

   hdmi_link_sequencer_if bus ();

   hdmi_link_sequencer #(
      .DEBOUNCE_CYCLES   (16),
      .SERDES_RST_CYCLES (8),
      .TIMING_RST_CYCLES (4)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [2:0] st, input logic [7:0] rc);
      chk({tag, ".state"},      32'(bus.o_state),      32'(st));
      chk({tag, ".serdes_rst"}, 32'(bus.o_serdes_rst), (st <= 3'd3) ? 32'd1 : 32'd0);
      chk({tag, ".timing_rst"}, 32'(bus.o_timing_rst), (st <= 3'd4) ? 32'd1 : 32'd0);
      chk({tag, ".video_en"},   32'(bus.o_video_en),   (st == 3'd6) ? 32'd1 : 32'd0);
      chk({tag, ".link_up"},    32'(bus.o_link_up),    (st == 3'd6) ? 32'd1 : 32'd0);
      chk({tag, ".relink_cnt"}, 32'(bus.o_relink_cnt), 32'(rc));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
      int k;
      k = 0;
      while ((bus.o_state !== st) && (k < budget)) begin
         step(1);
         k++;
      end
      chk({tag, ".reach"}, 32'(bus.o_state), 32'(st));
   endtask

   initial begin
`ifdef HDMI_HPD_BYPASS_EN
      // hot-plug held low throughout: bypass must still reach SERDES_RST
      vec[0] = '{1,  1'b1, 1'b0, 1'b0, 3'd1, 8'd0};
      vec[1] = '{2,  1'b1, 1'b0, 1'b0, 3'd2, 8'd0};
      vec[2] = '{1,  1'b1, 1'b0, 1'b0, 3'd3, 8'd0};
      vec[3] = '{8,  1'b1, 1'b0, 1'b0, 3'd4, 8'd0};
      vec[4] = '{4,  1'b1, 1'b0, 1'b0, 3'd5, 8'd0};
      vec[5] = '{1,  1'b1, 1'b0, 1'b1, 3'd6, 8'd0};
      vec[6] = '{2,  1'b1, 1'b0, 1'b0, 3'd6, 8'd0};
      nrows   = 7;
      rc_base = 0;
`else
      vec[0]  = '{1,  1'b1, 1'b1, 1'b0, 3'd1, 8'd0};
      vec[1]  = '{2,  1'b1, 1'b1, 1'b0, 3'd2, 8'd0};
      vec[2]  = '{15, 1'b1, 1'b1, 1'b0, 3'd2, 8'd0};
      vec[3]  = '{1,  1'b1, 1'b1, 1'b0, 3'd3, 8'd0};
      vec[4]  = '{7,  1'b1, 1'b1, 1'b0, 3'd3, 8'd0};
      vec[5]  = '{1,  1'b1, 1'b1, 1'b0, 3'd4, 8'd0};
      vec[6]  = '{3,  1'b1, 1'b1, 1'b0, 3'd4, 8'd0};
      vec[7]  = '{1,  1'b1, 1'b1, 1'b0, 3'd5, 8'd0};
      vec[8]  = '{28, 1'b1, 1'b1, 1'b0, 3'd5, 8'd0};
      vec[9]  = '{1,  1'b1, 1'b1, 1'b1, 3'd6, 8'd0};
      vec[10] = '{5,  1'b1, 1'b1, 1'b0, 3'd6, 8'd0};
      // 10-cycle HPD glitch is absorbed
      vec[11] = '{10, 1'b1, 1'b0, 1'b0, 3'd6, 8'd0};
      vec[12] = '{5,  1'b1, 1'b1, 1'b0, 3'd6, 8'd0};
      // sustained HPD loss: 2 sync + 16 debounce, exit on the 19th clock
      vec[13] = '{18, 1'b1, 1'b0, 1'b0, 3'd6, 8'd0};
      vec[14] = '{1,  1'b1, 1'b0, 1'b0, 3'd2, 8'd1};
      vec[15] = '{1,  1'b1, 1'b0, 1'b0, 3'd2, 8'd1};
      vec[16] = '{18, 1'b1, 1'b1, 1'b0, 3'd2, 8'd1};
      vec[17] = '{1,  1'b1, 1'b1, 1'b0, 3'd3, 8'd1};
      vec[18] = '{8,  1'b1, 1'b1, 1'b0, 3'd4, 8'd1};
      vec[19] = '{4,  1'b1, 1'b1, 1'b0, 3'd5, 8'd1};
      // lock drop lands with the frame pulse in WAIT_FRAME
      vec[20] = '{2,  1'b0, 1'b1, 1'b0, 3'd5, 8'd1};
      vec[21] = '{1,  1'b0, 1'b1, 1'b1, 3'd1, 8'd1};
      vec[22] = '{1,  1'b0, 1'b1, 1'b0, 3'd1, 8'd1};
      vec[23] = '{2,  1'b1, 1'b1, 1'b0, 3'd1, 8'd1};
      vec[24] = '{1,  1'b1, 1'b1, 1'b0, 3'd2, 8'd1};
      vec[25] = '{1,  1'b1, 1'b1, 1'b0, 3'd3, 8'd1};
      vec[26] = '{8,  1'b1, 1'b1, 1'b0, 3'd4, 8'd1};
      vec[27] = '{4,  1'b1, 1'b1, 1'b0, 3'd5, 8'd1};
      vec[28] = '{1,  1'b1, 1'b1, 1'b1, 3'd6, 8'd1};
      vec[29] = '{3,  1'b1, 1'b1, 1'b0, 3'd6, 8'd1};
      nrows   = 30;
      rc_base = 1;
`endif

      i_rst_n      = 1'b0;
      bus.i_locked = vec[0].lk;
      bus.i_hpd    = vec[0].hp;
      bus.i_frame  = 1'b0;
      step(3);
      check_outs("reset", 3'd0, 8'd0);
      i_rst_n = 1'b1;

      for (int i = 0; i < nrows; i++) begin
         bus.i_locked = vec[i].lk;
         bus.i_hpd    = vec[i].hp;
         bus.i_frame  = vec[i].fr;
         step(vec[i].cyc);
         check_outs($sformatf("row%0d", i), vec[i].st, vec[i].rc);
      end
      bus.i_frame = 1'b0;

      for (int n = 0; n < 300; n++) begin
         bus.i_locked = 1'b0;
         wait_state($sformatf("sat%0d.drop", n), 3'd1, 8);
         bus.i_locked = 1'b1;
         wait_state($sformatf("sat%0d.relock", n), 3'd5, 40);
         bus.i_frame = 1'b1;
         step(1);
         bus.i_frame = 1'b0;
         exp_rc = (rc_base + n + 1 > 255) ? 255 : rc_base + n + 1;
         chk($sformatf("sat%0d.run", n), 32'(bus.o_state), 32'd6);
         chk($sformatf("sat%0d.relink", n), 32'(bus.o_relink_cnt), 32'(exp_rc));
      end
      check_outs("sat.final", 3'd6, 8'd255);

      bus.i_locked = 1'b0;
      wait_state("midrst.drop", 3'd1, 8);
      bus.i_locked = 1'b1;
      wait_state("midrst.serdes", 3'd3, 20);
      #2 i_rst_n = 1'b0;
      #1 check_outs("midrst.async", 3'd0, 8'd0);
      step(1);
      check_outs("midrst.hold", 3'd0, 8'd0);
      i_rst_n = 1'b1;
      step(1);
      check_outs("midrst.restart", 3'd1, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
